// File: rtl/aes_uart_sequencer.sv
// Byte-level frame controller between a UART rx/tx pair and the aescipher core.
// Parses K/D/R command frames, commits key/plaintext, runs one encryption and streams replies.
module aes_uart_sequencer #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_done,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_done,
  output logic [127:0] aes_key,
  output logic [127:0] aes_din,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_dout,
  input  logic [127:0] aes_keyout,
  output logic         busy,
  output logic         rx_drop,
  output logic         timeout_err
);

  localparam logic [7:0] CMD_KEY  = 8'h4B;
  localparam logic [7:0] CMD_DATA = 8'h44;
  localparam logic [7:0] CMD_READ = 8'h52;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT_AES, S_SEND, S_SEND_WAIT} state_t;
  typedef enum logic [1:0] {R_ACK, R_NAK, R_CIPHER, R_KEYOUT} reply_t;

  state_t       state, state_nxt;
  reply_t       reply;
  logic [3:0]   cnt, tx_idx, tx_last;
  logic [31:0]  tmo;
  logic [127:0] shift_buf, res_dout, res_keyout;
  logic [127:0] buf_nxt, sel_word, shifted_word;
  logic         load_data, key_valid, res_valid;
  logic         last_byte, tmo_hit, payload_cmd;

  always_comb begin
    buf_nxt     = {shift_buf[119:0], rx_data};
    last_byte   = rx_done && (cnt == 4'd15);
    tmo_hit     = !rx_done && (tmo == 32'(TIMEOUT - 1));
    payload_cmd = (rx_data == CMD_KEY) || (rx_data == CMD_DATA);
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (rx_done) state_nxt = payload_cmd ? S_LOAD : S_SEND;
      S_LOAD: begin
        if (last_byte)    state_nxt = (load_data && key_valid) ? S_RUN : S_SEND;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_RUN:       state_nxt = S_WAIT_AES;
      S_WAIT_AES:  if (aes_done) state_nxt = S_SEND;
      S_SEND:      state_nxt = S_SEND_WAIT;
      S_SEND_WAIT: if (tx_done) state_nxt = (tx_idx == tx_last) ? S_IDLE : S_SEND;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != S_IDLE);
    aes_start    = (state == S_RUN);
    tx_start     = (state == S_SEND);
    sel_word     = (reply == R_CIPHER) ? res_dout : res_keyout;
    shifted_word = sel_word << {tx_idx, 3'b000};
    tx_data      = '0;
    if (state == S_SEND || state == S_SEND_WAIT) begin
      case (reply)
        R_ACK:   tx_data = ACK;
        R_NAK:   tx_data = NAK;
        default: tx_data = shifted_word[127:120];
      endcase
    end
  end

  // Reply kind/length chosen at frame decode; payload commands overwrite it at commit.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt         <= '0;
      tmo         <= '0;
      tx_idx      <= '0;
      tx_last     <= '0;
      reply       <= R_ACK;
      shift_buf   <= '0;
      res_dout    <= '0;
      res_keyout  <= '0;
      aes_key     <= '0;
      aes_din     <= '0;
      load_data   <= 1'b0;
      key_valid   <= 1'b0;
      res_valid   <= 1'b0;
      rx_drop     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (rx_done && (state inside {S_RUN, S_WAIT_AES, S_SEND, S_SEND_WAIT}))
        rx_drop <= 1'b1;
      case (state)
        S_IDLE: if (rx_done) begin
          load_data <= (rx_data == CMD_DATA);
          cnt       <= '0;
          tmo       <= '0;
          tx_idx    <= '0;
          if (rx_data == CMD_READ && res_valid) begin
            reply   <= R_KEYOUT;
            tx_last <= 4'd15;
          end else begin
            reply   <= R_NAK;
            tx_last <= '0;
          end
        end
        S_LOAD: begin
          if (rx_done) begin
            shift_buf <= buf_nxt;
            cnt       <= cnt + 4'd1;
            tmo       <= '0;
            if (cnt == 4'd15) begin
              if (load_data) begin
                aes_din <= buf_nxt;
                reply   <= key_valid ? R_CIPHER : R_NAK;
                tx_last <= key_valid ? 4'd15 : 4'd0;
              end else begin
                aes_key   <= buf_nxt;
                key_valid <= 1'b1;
                reply     <= R_ACK;
                tx_last   <= '0;
              end
            end
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            shift_buf   <= '0;
            cnt         <= '0;
            tmo         <= '0;
          end else begin
            tmo <= tmo + 32'd1;
          end
        end
        S_WAIT_AES: if (aes_done) begin
          res_dout   <= aes_dout;
          res_keyout <= aes_keyout;
          res_valid  <= 1'b1;
        end
        S_SEND_WAIT: if (tx_done && tx_idx != tx_last) tx_idx <= tx_idx + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_uart_sequencer.sv
// Self-checking bench for aes_uart_sequencer: vector table, hand-written corner sequences
// and random frames against a frame-level reference model with stand-in UART/AES responders.
module tb_aes_uart_sequencer;

  localparam int unsigned TMO     = 100;
  localparam int unsigned TX_LAT  = 4;
  localparam int unsigned AES_LAT = 6;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_RK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] ACK_REP  = {8'h06, 120'h0};
  localparam logic [127:0] NAK_REP  = {8'h15, 120'h0};

  logic         Clk, Rst;
  logic [7:0]   rx_data, tx_data;
  logic         rx_done, tx_start, tx_done;
  logic [127:0] aes_key, aes_din, aes_dout, aes_keyout;
  logic         aes_start, aes_done, busy, rx_drop, timeout_err;

  aes_uart_sequencer #(.TIMEOUT(TMO)) dut (
    .Clk(Clk), .Rst(Rst), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .aes_key(aes_key), .aes_din(aes_din), .aes_start(aes_start), .aes_done(aes_done),
    .aes_dout(aes_dout), .aes_keyout(aes_keyout),
    .busy(busy), .rx_drop(rx_drop), .timeout_err(timeout_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]   cmd;
    logic [127:0] pl;
    int unsigned  len;
    logic [127:0] rep;
    int unsigned  starts;
    logic [127:0] key;
    logic [127:0] din;
  } vec_t;

  int unsigned  n_checks, n_pass;
  logic [7:0]   txq[$];
  int unsigned  tx_cd, aes_cd, aes_starts;
  logic [127:0] aes_res_d, aes_res_k;
  // reference model state
  logic [127:0] m_key, m_din, m_ct, m_rk;
  logic         m_kv, m_rv;

  // Stand-in for the cipher core: exact FIPS-197 answer for the known vector, a mix otherwise.
  function automatic logic [255:0] fake_core(input logic [127:0] k, input logic [127:0] d);
    if (k == FIPS_KEY && d == FIPS_PT) return {FIPS_CT, FIPS_RK};
    return {k ^ {d[100:0], d[127:101]}, k + d};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One clock: sample outputs, run responders, drive inputs for the next rising edge.
  task automatic cycle(input logic rx_v, input logic [7:0] rx_b);
    logic [255:0] r;
    tx_done = 1'b0;
    if (tx_cd > 0) begin
      tx_cd--;
      tx_done = (tx_cd == 0);
    end
    if (tx_start) begin
      txq.push_back(tx_data);
      tx_cd = TX_LAT;
    end
    aes_done   = 1'b0;
    aes_dout   = {$urandom, $urandom, $urandom, $urandom};
    aes_keyout = {$urandom, $urandom, $urandom, $urandom};
    if (aes_cd > 0) begin
      aes_cd--;
      if (aes_cd == 0) begin
        aes_done   = 1'b1;
        aes_dout   = aes_res_d;
        aes_keyout = aes_res_k;
      end
    end
    if (aes_start) begin
      aes_starts++;
      r = fake_core(aes_key, aes_din);
      aes_res_d = r[255:128];
      aes_res_k = r[127:0];
      aes_cd = AES_LAT;
    end
    rx_done = rx_v;
    rx_data = rx_v ? rx_b : 8'($urandom);
    @(negedge Clk);
  endtask

  task automatic model_reset();
    m_key = '0; m_din = '0; m_ct = '0; m_rk = '0; m_kv = 1'b0; m_rv = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    Rst = 1'b0;
    tx_cd = 0; aes_cd = 0; txq.delete();
    model_reset();
  endtask

  task automatic model_frame(input logic [7:0] cmd, input logic [127:0] pl,
                             output int unsigned len, output logic [127:0] rep,
                             output int unsigned starts);
    logic [255:0] r;
    len = 1; rep = NAK_REP; starts = 0;
    case (cmd)
      8'h4B: begin m_key = pl; m_kv = 1'b1; rep = ACK_REP; end
      8'h44: begin
        m_din = pl;
        if (m_kv) begin
          r = fake_core(m_key, m_din);
          m_ct = r[255:128]; m_rk = r[127:0]; m_rv = 1'b1;
          len = 16; rep = m_ct; starts = 1;
        end
      end
      8'h52: if (m_rv) begin len = 16; rep = m_rk; end
      default: ;
    endcase
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [127:0] pl,
                            input int gap_idx, input int unsigned gap_len);
    int unsigned g;
    cycle(1'b1, cmd);
    if (cmd == 8'h4B || cmd == 8'h44) begin
      for (int i = 0; i < 16; i++) begin
        g = (i == gap_idx) ? gap_len : $urandom_range(0, 2);
        repeat (g) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'(pl >> (8 * (15 - i))));
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000 && (busy || tx_cd != 0); i++) cycle(1'b0, 8'h00);
  endtask

  function automatic logic [127:0] packed_reply();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < txq.size() && i < 16; i++) v[127 - 8 * i -: 8] = txq[i];
    return v;
  endfunction

  task automatic run_vector(input string name, input vec_t v);
    txq.delete();
    aes_starts = 0;
    send_frame(v.cmd, v.pl, -1, 0);
    wait_idle();
    check({name, "_idle"},   128'(busy), 128'(0));
    check({name, "_len"},    128'(txq.size()), 128'(v.len));
    check({name, "_reply"},  packed_reply(), v.rep);
    check({name, "_starts"}, 128'(aes_starts), 128'(v.starts));
    check({name, "_key"},    aes_key, v.key);
    check({name, "_din"},    aes_din, v.din);
  endtask

  task automatic run_model(input string name, input logic [7:0] cmd, input logic [127:0] pl);
    vec_t v;
    v.cmd = cmd; v.pl = pl;
    model_frame(cmd, pl, v.len, v.rep, v.starts);
    v.key = m_key; v.din = m_din;
    run_vector(name, v);
  endtask

  vec_t vt[6];

  initial begin
    int unsigned  dl, ds;
    logic [127:0] dr, pl;
    logic         inj, inj_now;
    logic [7:0]   cmd;

    n_checks = 0; n_pass = 0;
    tx_cd = 0; aes_cd = 0; aes_starts = 0;
    aes_res_d = '0; aes_res_k = '0;
    rx_done = 1'b0; rx_data = '0; tx_done = 1'b0; aes_done = 1'b0;
    aes_dout = '0; aes_keyout = '0;
    model_reset();

    vt[0] = '{8'h44, FIPS_PT,  1,  NAK_REP, 0, 128'h0,   FIPS_PT};
    vt[1] = '{8'h7A, 128'h0,   1,  NAK_REP, 0, 128'h0,   FIPS_PT};
    vt[2] = '{8'h52, 128'h0,   1,  NAK_REP, 0, 128'h0,   FIPS_PT};
    vt[3] = '{8'h4B, FIPS_KEY, 1,  ACK_REP, 0, FIPS_KEY, FIPS_PT};
    vt[4] = '{8'h44, FIPS_PT,  16, FIPS_CT, 1, FIPS_KEY, FIPS_PT};
    vt[5] = '{8'h52, 128'h0,   16, FIPS_RK, 0, FIPS_KEY, FIPS_PT};

    Rst = 1'b1;
    @(negedge Clk);
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    check("reset_ctl", 128'({tx_data, tx_start, aes_start, busy, rx_drop, timeout_err}), 128'(0));
    check("reset_key", aes_key, '0);
    check("reset_din", aes_din, '0);
    Rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      model_frame(vt[i].cmd, vt[i].pl, dl, dr, ds);
      run_vector($sformatf("vec%0d", i), vt[i]);
    end

    // Stray byte coincident with the final tx_done must be dropped.
    txq.delete();
    inj = 1'b0;
    model_frame(8'h4B, FIPS_KEY, dl, dr, ds);
    send_frame(8'h4B, FIPS_KEY, -1, 0);
    for (int i = 0; i < 400 && (busy || tx_cd != 0); i++) begin
      inj_now = (tx_cd == 1 && txq.size() == 1);
      if (inj_now) inj = 1'b1;
      cycle(inj_now, 8'h52);
    end
    check("final_done_inject", 128'(inj), 128'(1));
    check("final_done_reply", packed_reply(), ACK_REP);
    check("final_done_idle", 128'(busy), 128'(0));
    check("final_done_rx_drop", 128'(rx_drop), 128'(1));
    run_model("read_after_drop", 8'h52, '0);

    // A byte arriving exactly at counter expiry wins.
    do_reset();
    pl = {$urandom, $urandom, $urandom, $urandom};
    model_frame(8'h4B, pl, dl, dr, ds);
    txq.delete();
    send_frame(8'h4B, pl, 5, TMO - 1);
    wait_idle();
    check("edge_gap_reply", packed_reply(), ACK_REP);
    check("edge_gap_key", aes_key, pl);
    check("edge_gap_no_timeout", 128'(timeout_err), 128'(0));

    // Partial frame abandoned by inter-byte timeout.
    txq.delete();
    cycle(1'b1, 8'h4B);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom));
    repeat (TMO + 10) cycle(1'b0, 8'h00);
    check("timeout_err", 128'(timeout_err), 128'(1));
    check("timeout_idle", 128'(busy), 128'(0));
    check("timeout_key_kept", aes_key, m_key);
    check("timeout_no_tx", 128'(txq.size()), 128'(0));
    run_model("after_timeout_k", 8'h4B, {$urandom, $urandom, $urandom, $urandom});

    // Byte injected during WAIT_AES.
    check("pre_wait_rx_drop", 128'(rx_drop), 128'(0));
    pl = {$urandom, $urandom, $urandom, $urandom};
    model_frame(8'h44, pl, dl, dr, ds);
    txq.delete();
    aes_starts = 0;
    send_frame(8'h44, pl, -1, 0);
    for (int i = 0; i < 50 && aes_starts == 0; i++) cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'hA5);
    wait_idle();
    check("wait_drop_rx_drop", 128'(rx_drop), 128'(1));
    check("wait_drop_starts", 128'(aes_starts), 128'(1));
    check("wait_drop_reply", packed_reply(), dr);

    // Reset in the middle of a 16-byte reply.
    pl = {$urandom, $urandom, $urandom, $urandom};
    txq.delete();
    send_frame(8'h44, pl, -1, 0);
    for (int i = 0; i < 500 && txq.size() < 3; i++) cycle(1'b0, 8'h00);
    check("mid_send_reached", 128'(txq.size()), 128'(3));
    Rst = 1'b1;
    cycle(1'b0, 8'h00);
    check("mid_rst_ctl", 128'({tx_data, tx_start, aes_start, busy, rx_drop, timeout_err}), 128'(0));
    check("mid_rst_key", aes_key, '0);
    check("mid_rst_din", aes_din, '0);
    Rst = 1'b0;
    tx_cd = 0; aes_cd = 0; txq.delete();
    model_reset();
    run_model("post_rst_d_nak", 8'h44, {$urandom, $urandom, $urandom, $urandom});

    // Random frames against the model.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: cmd = 8'h4B;
        4, 5, 6:    cmd = 8'h44;
        7, 8:       cmd = 8'h52;
        default:    cmd = 8'($urandom);
      endcase
      run_model($sformatf("rnd%0d", n), cmd, {$urandom, $urandom, $urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_uart_sequencer.md
# aes_uart_sequencer

Byte-level frame controller between the UART receiver/transmitter pair and the `aescipher` core. It parses command frames arriving on the UART receive path, loads the 128-bit key and plaintext registers, starts one encryption, and streams the 16-byte ciphertext or last round key back through the UART transmitter. It replaces switch-driven byte selection with a self-sequencing protocol.

## Interface

**Parameters**
- `TIMEOUT`, default 50000: maximum number of `Clk` cycles allowed between bytes inside a frame.

**Ports**
- `Clk`, in, 1: system clock.
- `Rst`, in, 1: synchronous, active-high reset.
- `rx_data`, in, 8: received byte. Valid only while `rx_done` is high.
- `rx_done`, in, 1: one-cycle pulse marking a received byte.
- `tx_data`, out, 8: byte to transmit. Held stable from `tx_start` until `tx_done`.
- `tx_start`, out, 1: one-cycle request to transmit `tx_data`.
- `tx_done`, in, 1: one-cycle pulse when the transmitter finishes a byte.
- `aes_key`, out, 128: committed key register.
- `aes_din`, out, 128: committed plaintext register.
- `aes_start`, out, 1: one-cycle encryption start pulse.
- `aes_done`, in, 1: one-cycle pulse; `aes_dout` and `aes_keyout` are valid in this cycle.
- `aes_dout`, in, 128: ciphertext from the core.
- `aes_keyout`, in, 128: last round key from the core.
- `busy`, out, 1: high in any state other than IDLE.
- `rx_drop`, out, 1: sticky flag. Set when a byte arrives in RUN, WAIT_AES, SEND or SEND_WAIT. Cleared only by reset.
- `timeout_err`, out, 1: sticky flag. Set on an inter-byte timeout. Cleared only by reset.

## Operation

**Command bytes (first byte of a frame, accepted only in IDLE)**
- `0x4B` ('K'): 16 key bytes follow. When all 16 arrive, commit the key, set `key_valid`, and reply `0x06` (ACK).
- `0x44` ('D'): 16 plaintext bytes follow. When all 16 arrive, commit the plaintext.
  - If `key_valid` is set: start AES, then reply with the 16 ciphertext bytes.
  - Otherwise: reply `0x15` (NAK) and start nothing.
- `0x52` ('R'): if `res_valid` is set, reply with the 16 bytes of the captured `aes_keyout`. Otherwise reply NAK.
- Any other byte: reply NAK.

**Byte order**
- Byte assembly uses a separate 128-bit shift buffer: `buf <= {buf[119:0], rx_data}`.
- The first received byte therefore ends up in `[127:120]`.
- Transmission is also MSB byte first: `[127:120]`, then `[119:112]`, and so on.
- `aes_key` and `aes_din` change only at commit, i.e. on the 16th byte. A partially received frame never alters them.

**State machine**
- IDLE:
  - Valid command with payload → LOAD.
  - 'R' or an unknown command → SEND (with reply length 1 or 16).
- LOAD:
  - Each `rx_done` shifts in a byte and increments the 4-bit `cnt`.
  - On the byte where `cnt == 15`: commit, then go to RUN (for 'D' with `key_valid` set) or to SEND (ACK/NAK).
- RUN: assert `aes_start` for exactly one cycle, then go to WAIT_AES.
- WAIT_AES:
  - On `aes_done`, capture `aes_dout` and `aes_keyout` into the result registers and set `res_valid`.
  - Then go to SEND with a 16-byte reply.
  - There is no timeout in this state; only reset exits it.
- SEND: drive `tx_data` and pulse `tx_start`, then go to SEND_WAIT.
- SEND_WAIT:
  - On `tx_done`: if this was the last reply byte → IDLE; otherwise increment the byte index and go to SEND.

**Timeout**
- A 16-bit-or-wider counter runs only in LOAD and is cleared on every `rx_done`.
- When it reaches `TIMEOUT-1`: return to IDLE, discard the buffer, set `timeout_err`, and send no reply.

**Flags**
- `key_valid` and `res_valid` are cleared only by reset.

## Timing

**Reset values**
- All outputs are 0: `tx_data`, `tx_start`, `aes_key`, `aes_din`, `aes_start`, `busy`, `rx_drop`, `timeout_err`.
- Internal state: `key_valid = 0`, `res_valid = 0`, state = IDLE, `cnt = 0`.

**Latencies**
- Command `rx_done` in cycle N → state changes at edge N+1; `busy` is high from cycle N+1.
- 16th payload `rx_done` in cycle N → registers committed at edge N+1 → `aes_start` high in cycle N+1 only.
- `aes_done` in cycle M → `tx_start` high in cycle M+1, carrying byte `[127:120]`.
- `tx_done` in cycle K → next `tx_start` in cycle K+1.
- Final `tx_done` → IDLE at edge K+1. A command byte arriving in cycle K+1 is accepted.

**Boundary conditions**
- `rx_done` in the same cycle as timeout expiry: the byte wins, the counter clears, and there is no error.
- `Rst` in any state: returns to IDLE on the next edge and drops all pulses. A partial reply is abandoned.
- `rx_done` in the same cycle as the final `tx_done`: the byte is dropped and `rx_drop` is set.

## Test plan

1. **Encrypt (FIPS-197 vector).** Send 'K' followed by `000102…0f`. Expect ACK `0x06`. Send 'D' followed by `00112233445566778899aabbccddeeff`. Expect exactly one `aes_start` pulse, then 16 transmitted bytes `69c4e0d86a7b0430d8cdb78070b4c55a` in MSB-first order.
2. **No key loaded.** Immediately after reset, send 'D' plus 16 bytes. Expect one byte `0x15`, no `aes_start`, and `aes_din` updated.
3. **Command errors.** Send `0x7A` → expect NAK. Send 'R' before any encryption → expect NAK. Send 'R' after scenario 1 → expect 16 bytes `13111d7fe3944a17f307a78b4d2b30c5`.
4. **Timeout.** With `TIMEOUT=100`, send 'K' plus 5 bytes, then go idle for 100 cycles. Expect `timeout_err=1`, state IDLE, `aes_key` unchanged, no transmission. A following valid 'K' frame is accepted.
5. **Dropped bytes and reset.**
   - Inject `rx_done` while in WAIT_AES: `rx_drop=1` and the ciphertext is still sent correctly.
   - Assert `Rst` mid-SEND after 3 bytes: all outputs return to reset values next cycle and `key_valid=0`.
